dmem_responder: RTL and testbench

//  Data-memory responder serving the pipeline MEM-stage load/store requests (valid/ready request, pulsed response).

---
 rtl/Dmem_Resp_PKG.sv | 26 ++
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/Dmem_Resp_PKG.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 codes, the responder state type and the latched-request bundle.
package Dmem_Resp_PKG;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_t;

    // Word index is kept beside this bundle because its width follows
    // the DM_ADDRESS parameter of the responder.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane handling for the data-memory responder.
// Ports: we/funct3/lane/wdata in -> be, wdata_sh, err; rword in -> rdata
// (extended load data, zero for stores and for erroneous requests).
module dmem_lane_align
    import Dmem_Resp_PKG::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        err,
    output logic [31:0] rdata
);

    logic [31:0] rshift;

    always_comb begin
        err      = 1'b0;
        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = 32'h0;
        rshift   = rword >> {lane, 3'b000};

        case (funct3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = lane[0];
            F3_W:        err = (lane != 2'b00);
            default:     err = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (we && (funct3 == F3_BU || funct3 == F3_HU)) begin
            err = 1'b1;
        end

        // Replicating the store data lets the byte enables pick the lane.
        case (funct3)
            F3_B: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
            end
            F3_H: begin
                be       = 4'b0011 << {lane[1], 1'b0};
                wdata_sh = {2{wdata[15:0]}};
            end
            F3_W: begin
                be       = 4'b1111;
                wdata_sh = wdata;
            end
            default: be = 4'b0000;
        endcase
        if (err || !we) begin
            be = 4'b0000;
        end

        case (funct3)
            F3_B:  rdata = {{24{rshift[7]}}, rshift[7:0]};
            F3_BU: rdata = {24'h0, rshift[7:0]};
            F3_H:  rdata = {{16{rshift[15]}}, rshift[15:0]};
            F3_HU: rdata = {16'h0, rshift[15:0]};
            F3_W:  rdata = rshift;
            default: rdata = 32'h0;
        endcase
        if (err || we) begin
            rdata = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request, programmable
// wait states, one-cycle response pulse with extended load data / error flag.
// Ports: clk, reset (async, active-high), req_valid/req_ready, req_we,
// req_addr, req_wdata, req_funct3; rsp_valid, rsp_rdata, rsp_err.
// Define DMEM_FASTRESP_EN to accept a new request during the response cycle.
module dmem_responder
    import Dmem_Resp_PKG::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    if (DATA_W != 32) begin : g_bad_width
        $error("dmem_responder supports only DATA_W = 32");
    end

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

`ifdef DMEM_FASTRESP_EN
    localparam logic FAST = 1'b1;
`else
    localparam logic FAST = 1'b0;
`endif

    dmem_state_t           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic [DM_ADDRESS-3:0] idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        hs;
    logic        access;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic        lane_err;
    logic [31:0] lane_rdata;

    assign hs     = req_valid && ready_q;
    assign access = (state_q == ST_WAIT) && (cnt_q == 8'd0);

    dmem_lane_align u_align (
        .we       (req_q.we),
        .funct3   (req_q.funct3),
        .lane     (req_q.lane),
        .wdata    (req_q.wdata),
        .rword    (mem_q[idx_q]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .err      (lane_err),
        .rdata    (lane_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;

        // ready is only ever high in states that may take a request.
        if (hs) begin
            req_d.we     = req_we;
            req_d.funct3 = req_funct3;
            req_d.lane   = req_addr[1:0];
            req_d.wdata  = req_wdata[31:0];
            idx_d        = req_addr[DM_ADDRESS-1:2];
            cnt_d        = 8'(WAIT_CYCLES);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_WAIT;
                    ready_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = lane_rdata;
                    err_d       = lane_err;
                    ready_d     = FAST;
                end
            end
            ST_RESP: begin
                if (hs) begin
                    state_d = ST_WAIT;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_q       <= '0;
            idx_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Array is never cleared; a reset during WAIT drops state_q to IDLE
    // before the commit edge, so an abandoned store cannot land.
    always_ff @(posedge clk) begin
        if (access) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// load/store traffic compared with a byte-array reference model.
module tb_dmem_responder;

    localparam int WC = 2;

`ifdef DMEM_FASTRESP_EN
    localparam int PERIOD = WC + 2;
`else
    localparam int PERIOD = WC + 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [0:511];

    dmem_responder #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access-size / alignment rules of RV32I loads and stores.
    function automatic logic mdl_err(logic we, logic [2:0] f3, logic [8:0] a);
        int sz;
        if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
        else if (f3 == 3'd2) sz = 4;
        else return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        return (int'(a) % sz) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(logic [2:0] f3, logic [8:0] a);
        int v;
        int i;
        i = int'(a);
        case (f3)
            3'd0: begin v = int'(mdl[i]); if (v >= 128) v -= 256; end
            3'd4: v = int'(mdl[i]);
            3'd1: begin
                v = int'(mdl[i]) + 256 * int'(mdl[i+1]);
                if (v >= 32768) v -= 65536;
            end
            3'd5: v = int'(mdl[i]) + 256 * int'(mdl[i+1]);
            default: return {mdl[i+3], mdl[i+2], mdl[i+1], mdl[i]};
        endcase
        return 32'(v);
    endfunction

    task automatic mdl_store(logic [2:0] f3, logic [8:0] a, logic [31:0] d);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            mdl[int'(a) + k] = d[8*k +: 8];
        end
    endtask

    task automatic do_op(string tag, logic we, logic [8:0] a, logic [31:0] wd,
                         logic [2:0] f3, output logic [31:0] rd, output logic er);
        logic        exp_e;
        logic [31:0] exp_d;
        int          n;
        int          lat;
        exp_e = mdl_err(we, f3, a);
        exp_d = (we || exp_e) ? 32'h0 : mdl_load(f3, a);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/accept"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(WC + 1));
        chk({tag, "/rdata"}, rsp_rdata, exp_d);
        chk({tag, "/err"}, {31'h0, rsp_err}, {31'h0, exp_e});
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        chk({tag, "/pulse"}, {31'h0, rsp_valid}, 32'h0);
        if (we && !exp_e) mdl_store(f3, a, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        saw;
        int          acc[$];
        logic [8:0]  ra;
        logic [2:0]  rf;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        @(negedge clk);
        chk("rst/ready", {31'h0, req_ready}, 32'h1);
        chk("rst/valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst/err", {31'h0, rsp_err}, 32'h0);
        chk("rst/rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_op("sw010", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er);
        do_op("lw010", 1'b0, 9'h010, 32'h0, 3'b010, rd, er);
        chk("t1/lw", rd, 32'hDEADBEEF);

        do_op("sb013", 1'b1, 9'h013, 32'h00000080, 3'b000, rd, er);
        do_op("lb013", 1'b0, 9'h013, 32'h0, 3'b000, rd, er);
        chk("t2/lb", rd, 32'hFFFFFF80);
        do_op("lbu013", 1'b0, 9'h013, 32'h0, 3'b100, rd, er);
        chk("t2/lbu", rd, 32'h00000080);
        do_op("lw010b", 1'b0, 9'h010, 32'h0, 3'b010, rd, er);
        chk("t2/lw", rd, 32'h80ADBEEF);

        do_op("sh012", 1'b1, 9'h012, 32'h00001234, 3'b001, rd, er);
        do_op("lh012", 1'b0, 9'h012, 32'h0, 3'b001, rd, er);
        chk("t3/lh", rd, 32'h00001234);
        do_op("sh012b", 1'b1, 9'h012, 32'h00008001, 3'b001, rd, er);
        do_op("lhu012", 1'b0, 9'h012, 32'h0, 3'b101, rd, er);
        chk("t3/lhu", rd, 32'h00008001);
        do_op("lh012b", 1'b0, 9'h012, 32'h0, 3'b001, rd, er);
        chk("t3/lh2", rd, 32'hFFFF8001);

        do_op("lw011", 1'b0, 9'h011, 32'h0, 3'b010, rd, er);
        chk("t4/lw_err", {31'h0, er}, 32'h1);
        do_op("sh013", 1'b1, 9'h013, 32'h0000FFFF, 3'b001, rd, er);
        chk("t4/sh_err", {31'h0, er}, 32'h1);
        chk("t4/sh_rdata", rd, 32'h0);
        do_op("lw010c", 1'b0, 9'h010, 32'h0, 3'b010, rd, er);
        chk("t4/lw", rd, 32'h8001BEEF);

        // Reset abandons a store that is still waiting.
        do_op("sw020", 1'b1, 9'h020, 32'h13579BDF, 3'b010, rd, er);
        do_op("lw020pre", 1'b0, 9'h020, 32'h0, 3'b010, rd, er);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 9'h020;
        req_wdata  = 32'hAAAAAAAA;
        req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        saw       = 1'b0;
        @(negedge clk);
        chk("t5/rst_ready", {31'h0, req_ready}, 32'h1);
        chk("t5/rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("t5/no_rsp", {31'h0, saw}, 32'h0);
        do_op("lw020", 1'b0, 9'h020, 32'h0, 3'b010, rd, er);
        chk("t5/lw", rd, 32'h13579BDF);

        // Held request: count cycles between handshakes.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 9'h010;
        req_funct3 = 3'b010;
        for (int i = 0; i < 22; i++) begin
            if (req_valid && req_ready) acc.push_back(i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("t6/accepts", {31'h0, 1'(acc.size() >= 4)}, 32'h1);
        for (int i = 1; i < acc.size(); i++) begin
            chk("t6/period", 32'(acc[i] - acc[i-1]), 32'(PERIOD));
        end

        // Fill the array so every later load has defined contents.
        for (int w = 0; w < 128; w++) begin
            do_op("fill", 1'b1, 9'(w * 4), $urandom, 3'b010, rd, er);
        end

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (rf == 3'd1 || rf == 3'd5) ra[0] = 1'b0;
                if (rf == 3'd2) ra[1:0] = 2'b00;
            end
            do_op("rand", 1'($urandom_range(0, 1)), ra, $urandom, rf, rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
